// File: rtl/ibex_rf_access_seq.sv
// rtl/ibex_rf_access_seq.sv - command-driven sequencer for register file write port A and read ports A/B
module ibex_rf_access_seq #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 5,
    parameter int unsigned RdSettle  = 1,
    parameter bit          ZeroReg   = 1'b1,
    parameter int unsigned ErrCntW   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [1:0]           cmd_op_i,
    input  logic [AddrWidth-1:0] cmd_addr_a_i,
    input  logic [AddrWidth-1:0] cmd_addr_b_i,
    input  logic [DataWidth-1:0] cmd_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_a_o,
    output logic [DataWidth-1:0] rsp_rdata_b_o,
    output logic                 rsp_err_o,
    output logic [ErrCntW-1:0]   err_cnt_o,
    output logic [AddrWidth-1:0] rf_raddr_a_o,
    output logic [AddrWidth-1:0] rf_raddr_b_o,
    input  logic [DataWidth-1:0] rf_rdata_a_i,
    input  logic [DataWidth-1:0] rf_rdata_b_i,
    output logic [AddrWidth-1:0] rf_waddr_a_o,
    output logic [DataWidth-1:0] rf_wdata_a_o,
    output logic                 rf_we_a_o
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_WRV   = 2'b10;
    localparam logic [1:0] OP_PAIR  = 2'b11;
    localparam int unsigned CntW = (RdSettle > 1) ? $clog2(RdSettle) : 1;
    localparam logic [CntW-1:0] SettleLoad = CntW'(RdSettle - 1);

    typedef enum logic [1:0] {IDLE, WRITE, SETTLE, RESP} state_e;

    state_e                 state_q, state_d;
    logic [1:0]             op_q, op_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [DataWidth-1:0]   rsp_rdata_a_q, rsp_rdata_a_d;
    logic [DataWidth-1:0]   rsp_rdata_b_q, rsp_rdata_b_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [ErrCntW-1:0]     err_cnt_q, err_cnt_d;
    logic [AddrWidth-1:0]   raddr_a_q, raddr_a_d;
    logic [AddrWidth-1:0]   raddr_b_q, raddr_b_d;
    logic [AddrWidth-1:0]   waddr_q, waddr_d;
    logic [DataWidth-1:0]   wdata_q, wdata_d;
    logic                   we_q, we_d;
    logic [DataWidth-1:0]   verify_exp;
    logic                   mismatch;

    // The write address/data registers double as the command latch for WRITE_VERIFY readback.
    assign verify_exp = (ZeroReg && (waddr_q == '0)) ? '0 : wdata_q;
    assign mismatch   = (rf_rdata_a_i != verify_exp);

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        cnt_d         = cnt_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_a_d = rsp_rdata_a_q;
        rsp_rdata_b_d = rsp_rdata_b_q;
        rsp_err_d     = rsp_err_q;
        err_cnt_d     = err_cnt_q;
        raddr_a_d     = raddr_a_q;
        raddr_b_d     = raddr_b_q;
        waddr_d       = waddr_q;
        wdata_d       = wdata_q;
        we_d          = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid_i && cmd_ready_q) begin
                    op_d        = cmd_op_i;
                    cmd_ready_d = 1'b0;
                    if ((cmd_op_i == OP_WRITE) || (cmd_op_i == OP_WRV)) begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                        waddr_d = cmd_addr_a_i;
                        wdata_d = cmd_wdata_i;
                    end else begin
                        state_d   = SETTLE;
                        cnt_d     = SettleLoad;
                        raddr_a_d = cmd_addr_a_i;
                        if (cmd_op_i == OP_PAIR) begin
                            raddr_b_d = cmd_addr_b_i;
                        end
                    end
                end
            end
            WRITE: begin
                if (op_q == OP_WRITE) begin
                    state_d       = RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_a_d = '0;
                    rsp_rdata_b_d = '0;
                    rsp_err_d     = 1'b0;
                end else begin
                    state_d   = SETTLE;
                    cnt_d     = SettleLoad;
                    raddr_a_d = waddr_q;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d       = RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_a_d = rf_rdata_a_i;
                    rsp_rdata_b_d = (op_q == OP_PAIR) ? rf_rdata_b_i : '0;
                    rsp_err_d     = 1'b0;
                    if ((op_q == OP_WRV) && mismatch) begin
                        rsp_err_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            op_q          <= OP_READ;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_a_q <= '0;
            rsp_rdata_b_q <= '0;
            rsp_err_q     <= 1'b0;
            err_cnt_q     <= '0;
            raddr_a_q     <= '0;
            raddr_b_q     <= '0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            cnt_q         <= cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_a_q <= rsp_rdata_a_d;
            rsp_rdata_b_q <= rsp_rdata_b_d;
            rsp_err_q     <= rsp_err_d;
            err_cnt_q     <= err_cnt_d;
            raddr_a_q     <= raddr_a_d;
            raddr_b_q     <= raddr_b_d;
            waddr_q       <= waddr_d;
            wdata_q       <= wdata_d;
            we_q          <= we_d;
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_a_o = rsp_rdata_a_q;
    assign rsp_rdata_b_o = rsp_rdata_b_q;
    assign rsp_err_o     = rsp_err_q;
    assign err_cnt_o     = err_cnt_q;
    assign rf_raddr_a_o  = raddr_a_q;
    assign rf_raddr_b_o  = raddr_b_q;
    assign rf_waddr_a_o  = waddr_q;
    assign rf_wdata_a_o  = wdata_q;
    assign rf_we_a_o     = we_q;

endmodule
